// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one instruction/data RAM port between the instruction-fetch (IF)
//   requester and the memory-stage (MEM) requester. Each access lasts
//   WAIT_CYCLES cycles and ends with a one-cycle acknowledge carrying the read
//   word. MEM has fixed priority over IF because it holds the older
//   instruction. While any request is waiting, `stall` freezes the pipeline.
//
// Parameters
//   WAIT_CYCLES : RAM access length in cycles. Legal range is 1..15.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   if_req / if_addr         : IF read request and byte address
//   if_rdata / if_ack        : IF read word and one-cycle completion pulse
//   mem_req / mem_we         : MEM request and write select (1 = write)
//   mem_addr / mem_wdata     : MEM byte address and write data
//   mem_rdata / mem_ack      : MEM read word and one-cycle completion pulse
//   stall                    : pipeline stall (combinational)
//   ram_en / ram_we          : RAM access and write enables
//   ram_addr / ram_wdata     : RAM word address (addr[21:2]) and write data
//   ram_rdata                : RAM read data, valid in the last access cycle

module ram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        stall,
  output logic        ram_en,
  output logic        ram_we,
  output logic [19:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_MEM = 2'd1,
    BUSY_IF  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;

  // A requester still holding req during its own ack cycle is not a candidate,
  // otherwise the same request would be served twice.
  logic mem_cand;
  logic if_cand;

  assign mem_cand = mem_req & ~mem_ack;
  assign if_cand  = if_req & ~if_ack;
  assign stall    = if_cand | mem_cand;

  // Address bits outside the 1M-word RAM window and the byte offset are
  // intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:22], if_addr[1:0],
                              mem_addr[31:22], mem_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= 32'd0;
      mem_rdata <= 32'd0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= 20'd0;
      ram_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          // Acks live for exactly the first IDLE cycle after an access.
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
          if (mem_cand) begin
            ram_addr  <= mem_addr[21:2];
            ram_wdata <= mem_wdata;
            ram_we    <= mem_we;
            ram_en    <= 1'b1;
            cnt       <= 4'd0;
            state     <= BUSY_MEM;
          end else if (if_cand) begin
            ram_addr <= if_addr[21:2];
            ram_we   <= 1'b0;
            ram_en   <= 1'b1;
            cnt      <= 4'd0;
            state    <= BUSY_IF;
          end
        end

        BUSY_MEM, BUSY_IF: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            // Last busy cycle: ram_rdata is valid now, capture it for reads.
            if (state == BUSY_MEM) begin
              mem_ack <= 1'b1;
              if (!ram_we) begin
                mem_rdata <= ram_rdata;
              end
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= ram_rdata;
            end
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          state  <= IDLE;
          ram_en <= 1'b0;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed scenarios followed by randomized traffic for ram_arbiter.
//   A transaction-level reference model (grant cycle + fixed access length)
//   predicts every output each cycle for the WAIT_CYCLES=2 instance; a second
//   instance with WAIT_CYCLES=1 is checked against hand-derived constants.

module tb_ram_arbiter;

  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, ram_wdata, ram_rdata;
  logic        if_ack, mem_ack, stall, ram_en, ram_we;
  logic [19:0] ram_addr;

  logic        if_req_1, mem_req_1, mem_we_1;
  logic [31:0] if_addr_1, mem_addr_1, mem_wdata_1;
  logic [31:0] if_rdata_1, mem_rdata_1, ram_wdata_1, ram_rdata_1;
  logic        if_ack_1, mem_ack_1, stall_1, ram_en_1, ram_we_1;
  logic [19:0] ram_addr_1;

  ram_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_ack(if_ack_1),
    .mem_req(mem_req_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
    .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1), .mem_ack(mem_ack_1),
    .stall(stall_1), .ram_en(ram_en_1), .ram_we(ram_we_1), .ram_addr(ram_addr_1),
    .ram_wdata(ram_wdata_1), .ram_rdata(ram_rdata_1)
  );

  // Environment RAM seen by the main instance; the W=1 instance gets a
  // read-only RAM whose content is a function of the address.
  logic [31:0] env_ram [0:4095];
  assign ram_rdata   = env_ram[ram_addr[11:0]];
  assign ram_rdata_1 = 32'h3C00_0000 | {12'h000, ram_addr_1};

  // Reference model: expected outputs for the current cycle.
  logic [31:0] m_ram [0:4095];
  int          cyc;
  int          n_cmp;
  int          n_err;
  bit          acc_act;
  int          acc_g;
  bit          acc_mem;
  bit          acc_we;
  logic [19:0] acc_word;
  logic        e_ram_en, e_ram_we, e_if_ack, e_mem_ack;
  logic [19:0] e_ram_addr;
  logic [31:0] e_ram_wdata, e_if_rdata, e_mem_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
    end
  endtask

  // Advance the model from the current cycle (inputs applied) to the next.
  task automatic model_step();
    bit mc;
    bit ic;
    int nc;
    if (rst) begin
      acc_act     = 1'b0;
      e_ram_en    = 1'b0;
      e_ram_we    = 1'b0;
      e_if_ack    = 1'b0;
      e_mem_ack   = 1'b0;
      e_ram_addr  = 20'd0;
      e_ram_wdata = 32'd0;
      e_if_rdata  = 32'd0;
      e_mem_rdata = 32'd0;
    end else begin
      mc = mem_req && !e_mem_ack;
      ic = if_req && !e_if_ack;
      if (!acc_act && (mc || ic)) begin
        acc_act  = 1'b1;
        acc_g    = cyc;
        acc_mem  = mc;
        acc_we   = mc ? mem_we : 1'b0;
        acc_word = mc ? mem_addr[21:2] : if_addr[21:2];
        e_ram_addr = acc_word;
        if (mc) e_ram_wdata = mem_wdata;
        if (mc && mem_we) m_ram[acc_word[11:0]] = mem_wdata;
      end
      nc = cyc + 1;
      e_if_ack  = 1'b0;
      e_mem_ack = 1'b0;
      if (acc_act && nc == acc_g + W + 1) begin
        if (acc_mem) begin
          e_mem_ack = 1'b1;
          if (!acc_we) e_mem_rdata = m_ram[acc_word[11:0]];
        end else begin
          e_if_ack   = 1'b1;
          e_if_rdata = m_ram[acc_word[11:0]];
        end
        acc_act = 1'b0;
      end
      e_ram_en = acc_act && nc >= acc_g + 1 && nc <= acc_g + W;
      e_ram_we = e_ram_en && acc_we;
    end
  endtask

  // Check the current cycle, update the environment and model, then advance.
  task automatic cycle();
    #1;
    chk("stall", 32'(stall), 32'((if_req && !e_if_ack) || (mem_req && !e_mem_ack)));
    chk("ram_en", 32'(ram_en), 32'(e_ram_en));
    chk("ram_we", 32'(ram_we), 32'(e_ram_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_ram_addr));
    chk("ram_wdata", ram_wdata, e_ram_wdata);
    chk("if_ack", 32'(if_ack), 32'(e_if_ack));
    chk("mem_ack", 32'(mem_ack), 32'(e_mem_ack));
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("mem_rdata", mem_rdata, e_mem_rdata);
    if (ram_en === 1'b1 && ram_we === 1'b1) env_ram[ram_addr[11:0]] = ram_wdata;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[21:6] = 16'h0000;
    return a;
  endfunction

  bit if_ackp;
  bit mem_ackp;

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst = 1'b1;
    if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
    if_req_1 = 0; if_addr_1 = 0; mem_req_1 = 0; mem_we_1 = 0; mem_addr_1 = 0; mem_wdata_1 = 0;
    for (int i = 0; i < 4096; i++) begin
      env_ram[i] = $urandom;
      m_ram[i]   = env_ram[i];
    end
    env_ram[12'h040] = 32'h3C01_0001; m_ram[12'h040] = 32'h3C01_0001;
    env_ram[12'h800] = 32'h1234_5678; m_ram[12'h800] = 32'h1234_5678;
    acc_act = 0; acc_g = 0; acc_mem = 0; acc_we = 0; acc_word = 0;
    e_ram_en = 0; e_ram_we = 0; e_if_ack = 0; e_mem_ack = 0;
    e_ram_addr = 0; e_ram_wdata = 0; e_if_rdata = 0; e_mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    cycle();
    rst = 1'b0;
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_w1_ram_en", 32'(ram_en_1), 32'd0);
    cycle(); cycle();

    // IF read alone.
    if_req = 1; if_addr = 32'h0000_0100;
    cycle();
    chk("t1_en_c1", 32'(ram_en), 32'd1);
    chk("t1_addr_c1", 32'(ram_addr), 32'h040);
    chk("t1_we_c1", 32'(ram_we), 32'd0);
    cycle();
    chk("t1_en_c2", 32'(ram_en), 32'd1);
    chk("t1_stall_c2", 32'(stall), 32'd1);
    cycle();
    chk("t1_ack_c3", 32'(if_ack), 32'd1);
    chk("t1_rdata_c3", if_rdata, 32'h3C01_0001);
    chk("t1_en_c3", 32'(ram_en), 32'd0);
    chk("t1_stall_c3", 32'(stall), 32'd0);
    cycle();
    if_req = 0;
    chk("t1_en_c4", 32'(ram_en), 32'd0);
    chk("t1_ack_c4", 32'(if_ack), 32'd0);
    cycle(); cycle();

    // Simultaneous requests: MEM first, IF granted in MEM's ack cycle.
    if_req = 1; if_addr = 32'h0000_0200;
    mem_req = 1; mem_we = 0; mem_addr = 32'h0000_2000;
    cycle(); cycle(); cycle();
    chk("t2_mem_ack_c3", 32'(mem_ack), 32'd1);
    chk("t2_mem_rdata_c3", mem_rdata, 32'h1234_5678);
    chk("t2_stall_c3", 32'(stall), 32'd1);
    cycle();
    mem_req = 0;
    chk("t2_en_c4", 32'(ram_en), 32'd1);
    chk("t2_addr_c4", 32'(ram_addr), 32'h080);
    cycle();
    chk("t2_en_c5", 32'(ram_en), 32'd1);
    chk("t2_if_ack_c5", 32'(if_ack), 32'd0);
    cycle();
    chk("t2_if_ack_c6", 32'(if_ack), 32'd1);
    cycle();
    if_req = 0;
    cycle(); cycle();

    // MEM write, then read it back.
    mem_req = 1; mem_we = 1; mem_addr = 32'h0000_2004; mem_wdata = 32'hDEAD_BEEF;
    cycle();
    for (int k = 1; k <= 2; k++) begin
      chk("t3_en", 32'(ram_en), 32'd1);
      chk("t3_we", 32'(ram_we), 32'd1);
      chk("t3_addr", 32'(ram_addr), 32'h801);
      chk("t3_wdata", ram_wdata, 32'hDEAD_BEEF);
      cycle();
    end
    chk("t3_ack", 32'(mem_ack), 32'd1);
    chk("t3_rdata_kept", mem_rdata, 32'h1234_5678);
    cycle();
    mem_req = 0; mem_we = 0;
    chk("t3_single_ack", 32'(mem_ack), 32'd0);
    cycle();
    mem_req = 1; mem_addr = 32'h0000_2004;
    cycle(); cycle(); cycle();
    chk("t3_readback", mem_rdata, 32'hDEAD_BEEF);
    cycle();
    mem_req = 0;
    cycle();

    // Reset during the first busy cycle of an IF read; request stays high.
    if_req = 1; if_addr = 32'h0000_0104;
    cycle();
    chk("t4_en_c1", 32'(ram_en), 32'd1);
    rst = 1;
    cycle();
    rst = 0;
    chk("t4_en_after_rst", 32'(ram_en), 32'd0);
    chk("t4_no_ack", 32'(if_ack), 32'd0);
    chk("t4_addr_after_rst", 32'(ram_addr), 32'd0);
    cycle();
    chk("t4_en_c3", 32'(ram_en), 32'd1);
    cycle();
    chk("t4_en_c4", 32'(ram_en), 32'd1);
    cycle();
    chk("t4_ack_c5", 32'(if_ack), 32'd1);
    cycle();
    if_req = 0;
    cycle(); cycle();

    // WAIT_CYCLES=1 instance: back-to-back IF reads, request held through acks.
    if_req_1 = 1; if_addr_1 = 32'h0000_0100;
    #1 chk("t5_stall_c0", 32'(stall_1), 32'd1);
    cycle();
    chk("t5_en_c1", 32'(ram_en_1), 32'd1);
    chk("t5_addr_c1", 32'(ram_addr_1), 32'h040);
    chk("t5_ack_c1", 32'(if_ack_1), 32'd0);
    cycle();
    chk("t5_ack_c2", 32'(if_ack_1), 32'd1);
    chk("t5_rdata_c2", if_rdata_1, 32'h3C00_0040);
    chk("t5_en_c2", 32'(ram_en_1), 32'd0);
    if_addr_1 = 32'h0000_0108;
    #1 chk("t5_stall_c2", 32'(stall_1), 32'd0);
    cycle();
    chk("t5_ack_c3", 32'(if_ack_1), 32'd0);
    chk("t5_no_dup_c3", 32'(ram_en_1), 32'd0);
    chk("t5_stall_c3", 32'(stall_1), 32'd1);
    cycle();
    chk("t5_en_c4", 32'(ram_en_1), 32'd1);
    chk("t5_addr_c4", 32'(ram_addr_1), 32'h042);
    cycle();
    chk("t5_ack_c5", 32'(if_ack_1), 32'd1);
    chk("t5_rdata_c5", if_rdata_1, 32'h3C00_0042);
    cycle();
    if_req_1 = 0;
    chk("t6_en_c6", 32'(ram_en_1), 32'd0);
    chk("t6_ack_c6", 32'(if_ack_1), 32'd0);
    cycle();
    chk("t6_en_c7", 32'(ram_en_1), 32'd0);
    chk("t6_ack_c7", 32'(if_ack_1), 32'd0);
    cycle();

    // Randomized traffic: requesters hold req through their ack cycle.
    if_ackp = 0; mem_ackp = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (if_ackp) if_req = ($urandom_range(0, 3) == 0);
      else if (!if_req) if_req = ($urandom_range(0, 2) == 0);
      if_addr = rand_addr();
      if (mem_ackp) mem_req = ($urandom_range(0, 3) == 0);
      else if (!mem_req) mem_req = ($urandom_range(0, 2) == 0);
      mem_addr  = rand_addr();
      mem_we    = 1'($urandom_range(0, 1));
      mem_wdata = $urandom;
      if_ackp  = e_if_ack;
      mem_ackp = e_mem_ack;
      cycle();
    end
    rst = 0; if_req = 0; mem_req = 0;
    repeat (6) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
